// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC and fetch stage driving a word-indexed instruction memory
// Registers {instr, pc, pc+4} into a valid/ready fetch-to-decode output; handles redirect, halt and faults.
module instr_fetch_unit #(
    parameter int                 BITSIZE    = 32,
    parameter int                 REGSIZE    = 32,
    parameter int                 IMEM_DEPTH = 32,
    parameter logic [REGSIZE-1:0] RESET_PC   = 32'h0000_0004,
    parameter logic [BITSIZE-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [REGSIZE-1:0] imem_addr,
    input  logic [BITSIZE-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [REGSIZE-1:0] redirect_pc,
    input  logic               halt_req,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [BITSIZE-1:0] if_instr,
    output logic [REGSIZE-1:0] if_pc,
    output logic [REGSIZE-1:0] if_pc_plus4,
    output logic               fetch_fault,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    localparam logic [REGSIZE-1:0] DEPTH_W = REGSIZE'(IMEM_DEPTH);
    localparam logic [REGSIZE-1:0] PC_STEP = REGSIZE'(4);

    state_t             state_q, state_d;
    logic [REGSIZE-1:0] pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [BITSIZE-1:0] instr_q, instr_d;
    logic [REGSIZE-1:0] ipc_q, ipc_d;
    logic [REGSIZE-1:0] ipc4_q, ipc4_d;
    logic               fault_q, fault_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        count_q, count_d;
    logic               in_range;
    logic               transfer;

    assign imem_addr = {2'b00, pc_q[REGSIZE-1:2]};
    assign in_range  = imem_addr < DEPTH_W;
    assign transfer  = valid_q && if_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        ipc4_d     = ipc4_q;
        fault_d    = fault_q;
        misalign_d = misalign_q;
        count_d    = transfer ? count_q + 32'd1 : count_q;

        if (state_q == S_BOOT) begin
            state_d = S_RUN;
        end else if (redirect_valid) begin
            // A handshake completing alongside the redirect is still counted above.
            pc_d    = {redirect_pc[REGSIZE-1:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = S_RUN;
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else begin
            if (transfer) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            if (state_q == S_RUN) begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!in_range) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (!valid_q || if_ready) begin
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + PC_STEP;
                    pc_d    = pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            ipc_q      <= '0;
            ipc4_q     <= '0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            ipc4_q     <= ipc4_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = ipc_q;
    assign if_pc_plus4  = ipc4_q;
    assign fetch_fault  = fault_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule
